// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic-array controller:
//   - state_t   : controller FSM states
//   - N_DEF     : default array dimension (N x N processing elements)
//   - DW_DEF    : default operand element width
//   - FEED_LEN  : operand read cycles per job (N)
//   - DRAIN_LEN : cycles to let the last operands reach PE(N-1,N-1) (2N-1)
// feed_len()/drain_len() give the same lengths for a non-default N.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N_DEF     = 16;
    localparam int DW_DEF    = 8;
    localparam int FEED_LEN  = N_DEF;
    localparam int DRAIN_LEN = 2 * N_DEF - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic int feed_len(input int n);
        return n;
    endfunction

    // One read latency plus 2(n-1) PE hops to the far corner.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_skew.sv
// -----------------------------------------------------------------------------
// systolic_skew
// Diagonal skew for one array edge. Lane i delays its element by i cycles so
// that operand k reaches row/column i one cycle after it reaches row/column
// i-1. Lanes are zero-filled: when the input is not valid, zero enters the
// delay line, so a lane never shows stale or unreturned data.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset, clears every delay stage
//   flush : synchronous clear of every delay stage
//   vld   : din holds valid returned data this cycle
//   din   : N lanes of DW bits, lane i at [i*DW +: DW]
//   dout  : skewed lanes; lane 0 is combinational (zero delay)
// -----------------------------------------------------------------------------
module systolic_skew
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          vld,
    input  logic [N*DW-1:0] din,
    output logic [N*DW-1:0] dout
);

    logic [N*DW-1:0] din_gated;

    assign din_gated = vld ? din : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign dout[DW-1:0] = din_gated[DW-1:0];
        end else begin : g_dly
            logic [DW-1:0] sr [i];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else if (flush) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= din_gated[i*DW +: DW];
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end

            assign dout[i*DW +: DW] = sr[i-1];
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequences one N x N matrix multiply on an output-stationary systolic array:
// CLEAR (1 cycle) -> FEED (N operand reads) -> DRAIN (2N-1) -> DONE (1 cycle).
// Operand column k of A and row k of B return one cycle after the read and
// are skewed onto the west/north array edges.
// Ports:
//   clk, rst        : clock; asynchronous active-low reset
//   start           : request a job (sampled only in IDLE)
//   abort           : cancel the job in CLEAR/FEED/DRAIN
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse in DONE
//   op_rd_en/op_rd_k: operand memory read strobe and index k
//   a_col, b_row    : returned A column / B row, valid 1 cycle after read
//   arr_a, arr_b    : skewed west-edge and north-edge feeds
//   arr_clr, arr_en : clear PE accumulators; advance/accumulate the array
// -----------------------------------------------------------------------------
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 op_rd_en,
    output logic [$clog2(N)-1:0] op_rd_k,
    input  logic [N*DW-1:0]      a_col,
    input  logic [N*DW-1:0]      b_row,
    output logic [N*DW-1:0]      arr_a,
    output logic [N*DW-1:0]      arr_b,
    output logic                 arr_clr,
    output logic                 arr_en
);

    localparam int KW = $clog2(N);
    localparam int CW = $clog2(2 * N);

    localparam logic [CW-1:0] FEED_LAST  = CW'(feed_len(N) - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(drain_len(N) - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          kill;
    logic          flush;
    logic          rd_vld_p0;

    // Abort only acts while a job is actually running.
    assign kill  = abort && ((state == ST_CLEAR) || (state == ST_FEED) ||
                             (state == ST_DRAIN));
    assign flush = kill || (state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_rd_en <= 1'b0;
            op_rd_k  <= '0;
            arr_clr  <= 1'b0;
            arr_en   <= 1'b0;
        end else if (kill) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            op_rd_en <= 1'b0;
            op_rd_k  <= '0;
            arr_clr  <= 1'b0;
            arr_en   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        arr_clr <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state    <= ST_FEED;
                    cnt      <= '0;
                    arr_clr  <= 1'b0;
                    op_rd_en <= 1'b1;
                    op_rd_k  <= '0;
                    arr_en   <= 1'b1;
                end
                ST_FEED: begin
                    if (cnt == FEED_LAST) begin
                        state    <= ST_DRAIN;
                        cnt      <= '0;
                        op_rd_en <= 1'b0;
                        op_rd_k  <= '0;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        op_rd_k <= op_rd_k + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state  <= ST_DONE;
                        cnt    <= '0;
                        arr_en <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    op_rd_en <= 1'b0;
                    op_rd_k  <= '0;
                    arr_clr  <= 1'b0;
                    arr_en   <= 1'b0;
                end
            endcase
        end
    end

    // ---- p0: read data returns; a read issued in an aborting cycle is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_p0 <= 1'b0;
        end else begin
            rd_vld_p0 <= op_rd_en && !kill;
        end
    end

    systolic_skew #(.N(N), .DW(DW)) u_skew_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .vld   (rd_vld_p0),
        .din   (a_col),
        .dout  (arr_a)
    );

    systolic_skew #(.N(N), .DW(DW)) u_skew_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .vld   (rd_vld_p0),
        .din   (b_row),
        .dout  (arr_b)
    );

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    localparam int N   = 16;
    localparam int DW  = 8;
    localparam int KW  = $clog2(N);
    localparam int JOB = 3 * N + 1;

    logic            clk = 1'b0;
    logic            rst, start, abort;
    logic            busy, done, op_rd_en, arr_clr, arr_en;
    logic [KW-1:0]   op_rd_k;
    logic [N*DW-1:0] a_col, b_row, arr_a, arr_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];
    int exp_done_q[$];
    int exp_c_q[$];

    logic [DW-1:0] pa [N][N];
    logic [DW-1:0] pb [N][N];
    int acc [N][N];
    int en_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_ctrl #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .op_rd_en (op_rd_en),
        .op_rd_k  (op_rd_k),
        .a_col    (a_col),
        .b_row    (b_row),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .arr_clr  (arr_clr),
        .arr_en   (arr_en)
    );

    // Operand memory: one-cycle read latency, random junk when not reading.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] <= op_rd_en ? ma[i][op_rd_k] : DW'($urandom);
            b_row[i*DW +: DW] <= op_rd_en ? mb[op_rd_k][i] : DW'($urandom);
        end
    end

    // Output-stationary PE array fed by the DUT.
    function automatic logic [DW-1:0] a_in(input int i, input int j);
        if (j == 0) return arr_a[i*DW +: DW];
        else        return pa[i][j-1];
    endfunction

    function automatic logic [DW-1:0] b_in(input int i, input int j);
        if (i == 0) return arr_b[j*DW +: DW];
        else        return pb[i-1][j];
    endfunction

    always @(posedge clk) begin
        if (arr_clr) begin
            en_cnt <= 0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                    acc[i][j] <= 0;
                end
        end else if (arr_en) begin
            en_cnt <= en_cnt + 1;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                    acc[i][j] <= acc[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
                end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain matrix product and the job length from the phase rules.
    task automatic push_job(input int done_cyc);
        int s;
        exp_done_q.push_back(done_cyc);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += int'(ma[i][k]) * int'(mb[k][j]);
                exp_c_q.push_back(s);
            end
    endtask

    // mode 0 random, 1 identity x (k*16+j), 2 all ones, 3 skew pattern
    task automatic fill(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                case (mode)
                    1: begin ma[r][c] = DW'(r == c); mb[r][c] = DW'(r * 16 + c); end
                    2: begin ma[r][c] = DW'(1);      mb[r][c] = DW'(1); end
                    3: begin ma[r][c] = (c == 0) ? DW'(r + 1) : DW'(0); mb[r][c] = DW'($urandom); end
                    default: begin ma[r][c] = DW'($urandom); mb[r][c] = DW'($urandom); end
                endcase
            end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        int dc;
        int ec;
        if (rst && done) begin
            if (exp_done_q.size() == 0) begin
                chk("done_without_job", 64'(done), 64'(0));
            end else begin
                dc = exp_done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(dc));
                chk("arr_en_cycles", 64'(en_cnt), 64'(3 * N - 1));
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        ec = exp_c_q.pop_front();
                        chk($sformatf("C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(ec));
                    end
            end
        end else if (exp_done_q.size() > 0 && cyc > exp_done_q[0]) begin
            chk("done_by_expected_cycle", 64'(done), 64'(1));
            dc = exp_done_q.pop_front();
            for (int n = 0; n < N * N; n++) ec = exp_c_q.pop_front();
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     64'(busy),     64'(0));
        chk({tag, "_done"},     64'(done),     64'(0));
        chk({tag, "_op_rd_en"}, 64'(op_rd_en), 64'(0));
        chk({tag, "_op_rd_k"},  64'(op_rd_k),  64'(0));
        chk({tag, "_arr_clr"},  64'(arr_clr),  64'(0));
        chk({tag, "_arr_en"},   64'(arr_en),   64'(0));
        chk({tag, "_arr_a0"},   64'(arr_a == '0), 64'(1));
        chk({tag, "_arr_b0"},   64'(arr_b == '0), 64'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'($urandom_range(0, 1));
            chk("idle_busy", 64'(busy), 64'(0));
        end
        abort = 1'b0;
    endtask

    // One job: d counts cycles after the IDLE cycle that accepts start.
    task automatic run_job(input int abort_d, input int rst_d, input bit skew);
        @(negedge clk);
        start = 1'b1;
        abort = 1'($urandom_range(0, 1));
        if (abort_d < 0 && rst_d < 0) push_job(cyc + JOB);
        for (int d = 1; d <= JOB; d++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            abort = 1'b0;
            chk("busy",     64'(busy),     64'(1));
            chk("arr_clr",  64'(arr_clr),  64'(d == 1));
            chk("op_rd_en", 64'(op_rd_en), 64'(d >= 2 && d <= N + 1));
            chk("op_rd_k",  64'(op_rd_k),  64'((d >= 2 && d <= N + 1) ? d - 2 : 0));
            chk("arr_en",   64'(arr_en),   64'(d >= 2 && d <= 3 * N));
            chk("done",     64'(done),     64'(d == JOB));
            if (skew) begin
                if (d == 2) chk("skew_a0_pre",  64'(arr_a[0 +: DW]),    64'(0));
                if (d == 3) chk("skew_a0",      64'(arr_a[0 +: DW]),    64'(1));
                if (d == 5) chk("skew_a3_pre",  64'(arr_a[3*DW +: DW]), 64'(0));
                if (d == 6) chk("skew_a3",      64'(arr_a[3*DW +: DW]), 64'(4));
                if (d == 6) chk("skew_b3",      64'(arr_b[3*DW +: DW]), 64'(mb[0][3]));
                if (d == 7) chk("skew_a3_post", 64'(arr_a[3*DW +: DW]), 64'(0));
            end
            if (d == JOB) begin
                start = 1'b1;
                abort = 1'($urandom_range(0, 1));
            end
            if (d == abort_d) begin
                start = 1'b0;
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy",     64'(busy),     64'(0));
                chk("abort_done",     64'(done),     64'(0));
                chk("abort_op_rd_en", 64'(op_rd_en), 64'(0));
                chk("abort_arr_en",   64'(arr_en),   64'(0));
                chk("abort_arr_a",    64'(arr_a == '0), 64'(1));
                chk("abort_arr_b",    64'(arr_b == '0), 64'(1));
                return;
            end
            if (d == rst_d) begin
                start = 1'b0;
                rst   = 1'b0;
                #1;
                chk_all_zero("midrst");
                @(negedge clk);
                rst = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        idle(2);

        fill(1); run_job(-1, -1, 1'b0);        // identity: C == B
        fill(2); run_job(-1, -1, 1'b0);        // back to back, all ones
        idle(1);
        fill(3); run_job(-1, -1, 1'b1);        // skew pattern
        idle(2);

        // start held high: accepted every 3N+2 cycles
        fill(0);
        for (int d = 0; d <= 3 * (JOB + 1); d++) begin
            @(negedge clk);
            start = (d < 3 * (JOB + 1)) ? 1'b1 : 1'b0;
            if (d % (JOB + 1) == 0 && d < 3 * (JOB + 1)) push_job(cyc + JOB);
            chk("held_busy", 64'(busy), 64'(d % (JOB + 1) != 0));
        end
        idle(2);

        fill(0); run_job(7, -1, 1'b0);         // abort at FEED cycle 5
        idle(4);
        fill(0); run_job(-1, N + 2 + 10, 1'b0); // reset at DRAIN cycle 10
        idle(2);
        fill(0); run_job(-1, -1, 1'b0);
        for (int r = 0; r < 2; r++) begin
            fill(0);
            run_job(-1, -1, 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(4);
        chk("scoreboard_empty", 64'(exp_done_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
